// File: rtl/alu_rs_scheduler_pkg.sv
// Shared types for the ALU reservation station: widths, opcode enum, entry record.
package alu_rs_scheduler_pkg;

    localparam int RS_SIZE = 8;
    localparam int OPT_W   = 6;
    localparam int DATA_W  = 32;
    localparam int ROB_W   = 4;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ROB_W-1:0]  rob_t;

    typedef enum logic [OPT_W-1:0] {
        OPT_NONE, OPT_LUI, OPT_AUIPC, OPT_JAL, OPT_JALR,
        OPT_BEQ, OPT_BNE, OPT_BLT, OPT_BGE, OPT_BLTU, OPT_BGEU,
        OPT_ADDI, OPT_SLTI, OPT_SLTIU, OPT_XORI, OPT_ORI, OPT_ANDI,
        OPT_SLLI, OPT_SRLI, OPT_SRAI,
        OPT_ADD, OPT_SUB, OPT_SLL, OPT_SLT, OPT_SLTU, OPT_XOR,
        OPT_SRL, OPT_SRA, OPT_OR, OPT_AND
    } opt_e;

    // One station slot; busy is kept outside so it can carry the reset.
    typedef struct packed {
        opt_e  opt;
        data_t vj;
        data_t vk;
        rob_t  qj;
        rob_t  qk;
        logic  rj;
        logic  rk;
        data_t imm;
        data_t pc;
        rob_t  rob;
    } rs_entry_t;

    // True when a valid broadcast carries the tag an operand is waiting on.
    function automatic logic cdb_hit(logic v, rob_t tag, rob_t q);
        return v && (tag == q);
    endfunction

endpackage

// File: rtl/alu_rs_scheduler_if.sv
// Dispatch, CDB snoop and issue bundle between the dispatcher, the RS and the ALU.
interface alu_rs_scheduler_if;
    import alu_rs_scheduler_pkg::*;

    logic  disp_valid;
    opt_e  disp_opt;
    data_t disp_vj;
    data_t disp_vk;
    rob_t  disp_qj;
    rob_t  disp_qk;
    logic  disp_qj_ready;
    logic  disp_qk_ready;
    data_t disp_imm;
    data_t disp_pc;
    rob_t  disp_rob;
    logic  rs_full;

    logic  cdb0_valid;
    rob_t  cdb0_rob;
    data_t cdb0_val;
    logic  cdb1_valid;
    rob_t  cdb1_rob;
    data_t cdb1_val;

    logic  issue_valid;
    opt_e  issue_opt;
    data_t issue_rs1;
    data_t issue_rs2;
    data_t issue_imm;
    data_t issue_pc;
    rob_t  issue_rob;

    modport master (
        output disp_valid, disp_opt, disp_vj, disp_vk, disp_qj, disp_qk,
               disp_qj_ready, disp_qk_ready, disp_imm, disp_pc, disp_rob,
               cdb0_valid, cdb0_rob, cdb0_val, cdb1_valid, cdb1_rob, cdb1_val,
        input  rs_full, issue_valid, issue_opt, issue_rs1, issue_rs2,
               issue_imm, issue_pc, issue_rob
    );

    modport slave (
        input  disp_valid, disp_opt, disp_vj, disp_vk, disp_qj, disp_qk,
               disp_qj_ready, disp_qk_ready, disp_imm, disp_pc, disp_rob,
               cdb0_valid, cdb0_rob, cdb0_val, cdb1_valid, cdb1_rob, cdb1_val,
        output rs_full, issue_valid, issue_opt, issue_rs1, issue_rs2,
               issue_imm, issue_pc, issue_rob
    );

endinterface

// File: rtl/alu_rs_scheduler_select.sv
// Lowest-set-bit priority encoder: index of the first 1 in i_vec plus a found flag.
module rs_select_lsb #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_vec,
    output logic [IW-1:0] o_idx,
    output logic          o_found
);

    // Scan from the top down so the lowest set bit is the last to win.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx   = IW'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rs_scheduler.sv
// ALU reservation station: buffers dispatched ops, snoops two CDB ports,
// issues the lowest-index ready entry per cycle through a registered stage.
module alu_rs_scheduler #(
    parameter int RS_SIZE = alu_rs_scheduler_pkg::RS_SIZE
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                clear_in,
    alu_rs_scheduler_if.slave   bus
);
    import alu_rs_scheduler_pkg::*;

    localparam int IDX_W = $clog2(RS_SIZE);
    localparam int OCC_W = IDX_W + 1;

    logic [RS_SIZE-1:0] r_busy;
    rs_entry_t          r_ent [RS_SIZE];
    logic [OCC_W-1:0]   r_occ;

    logic               r_iss_valid;
    opt_e               r_iss_opt;
    data_t              r_iss_rs1;
    data_t              r_iss_rs2;
    data_t              r_iss_imm;
    data_t              r_iss_pc;
    rob_t               r_iss_rob;

    logic [RS_SIZE-1:0] w_ready;
    logic [RS_SIZE-1:0] w_free_vec;
    logic [IDX_W-1:0]   w_iss_idx;
    logic [IDX_W-1:0]   w_free_idx;
    logic               w_iss_found;
    logic               w_free_found;
    logic               w_full;
    logic               w_disp_go;
    rs_entry_t          w_new;

    // Ready and free vectors come from pre-edge state only, so a slot freed
    // by issue this edge is still seen as busy and cannot be refilled yet.
    always_comb begin
        w_ready = '0;
        for (int i = 0; i < RS_SIZE; i++)
            w_ready[i] = r_busy[i] & r_ent[i].rj & r_ent[i].rk;
    end

    assign w_free_vec = ~r_busy;
    assign w_full     = (r_occ == OCC_W'(RS_SIZE));
    assign w_disp_go  = bus.disp_valid & ~w_full & w_free_found;

    rs_select_lsb #(.N(RS_SIZE), .IW(IDX_W)) u_sel_issue (
        .i_vec   (w_ready),
        .o_idx   (w_iss_idx),
        .o_found (w_iss_found)
    );

    rs_select_lsb #(.N(RS_SIZE), .IW(IDX_W)) u_sel_free (
        .i_vec   (w_free_vec),
        .o_idx   (w_free_idx),
        .o_found (w_free_found)
    );

    // Build the incoming entry, forwarding a same-cycle CDB result (cdb0 first).
    always_comb begin
        w_new.opt = bus.disp_opt;
        w_new.vj  = bus.disp_vj;
        w_new.vk  = bus.disp_vk;
        w_new.qj  = bus.disp_qj;
        w_new.qk  = bus.disp_qk;
        w_new.rj  = bus.disp_qj_ready;
        w_new.rk  = bus.disp_qk_ready;
        w_new.imm = bus.disp_imm;
        w_new.pc  = bus.disp_pc;
        w_new.rob = bus.disp_rob;
        if (!bus.disp_qj_ready) begin
            if (cdb_hit(bus.cdb0_valid, bus.cdb0_rob, bus.disp_qj)) begin
                w_new.vj = bus.cdb0_val;
                w_new.rj = 1'b1;
            end else if (cdb_hit(bus.cdb1_valid, bus.cdb1_rob, bus.disp_qj)) begin
                w_new.vj = bus.cdb1_val;
                w_new.rj = 1'b1;
            end
        end
        if (!bus.disp_qk_ready) begin
            if (cdb_hit(bus.cdb0_valid, bus.cdb0_rob, bus.disp_qk)) begin
                w_new.vk = bus.cdb0_val;
                w_new.rk = 1'b1;
            end else if (cdb_hit(bus.cdb1_valid, bus.cdb1_rob, bus.disp_qk)) begin
                w_new.vk = bus.cdb1_val;
                w_new.rk = 1'b1;
            end
        end
    end

    // Control state: busy bits, occupancy and the issue register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_busy      <= '0;
            r_occ       <= '0;
            r_iss_valid <= 1'b0;
            r_iss_opt   <= OPT_NONE;
            r_iss_rs1   <= '0;
            r_iss_rs2   <= '0;
            r_iss_imm   <= '0;
            r_iss_pc    <= '0;
            r_iss_rob   <= '0;
        end else if (rdy_in) begin
            if (clear_in) begin
                r_busy      <= '0;
                r_occ       <= '0;
                r_iss_valid <= 1'b0;
            end else begin
                r_iss_valid <= w_iss_found;
                if (w_iss_found) begin
                    r_iss_opt           <= r_ent[w_iss_idx].opt;
                    r_iss_rs1           <= r_ent[w_iss_idx].vj;
                    r_iss_rs2           <= r_ent[w_iss_idx].vk;
                    r_iss_imm           <= r_ent[w_iss_idx].imm;
                    r_iss_pc            <= r_ent[w_iss_idx].pc;
                    r_iss_rob           <= r_ent[w_iss_idx].rob;
                    r_busy[w_iss_idx]   <= 1'b0;
                end
                if (w_disp_go)
                    r_busy[w_free_idx] <= 1'b1;
                r_occ <= r_occ - OCC_W'(w_iss_found) + OCC_W'(w_disp_go);
            end
        end
    end

    // Entry payload: snoop waiting operands, then write the dispatched slot.
    // Payload is only meaningful while busy, so it carries no reset.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !clear_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (r_busy[i]) begin
                    if (!r_ent[i].rj) begin
                        if (cdb_hit(bus.cdb0_valid, bus.cdb0_rob, r_ent[i].qj)) begin
                            r_ent[i].vj <= bus.cdb0_val;
                            r_ent[i].rj <= 1'b1;
                        end else if (cdb_hit(bus.cdb1_valid, bus.cdb1_rob, r_ent[i].qj)) begin
                            r_ent[i].vj <= bus.cdb1_val;
                            r_ent[i].rj <= 1'b1;
                        end
                    end
                    if (!r_ent[i].rk) begin
                        if (cdb_hit(bus.cdb0_valid, bus.cdb0_rob, r_ent[i].qk)) begin
                            r_ent[i].vk <= bus.cdb0_val;
                            r_ent[i].rk <= 1'b1;
                        end else if (cdb_hit(bus.cdb1_valid, bus.cdb1_rob, r_ent[i].qk)) begin
                            r_ent[i].vk <= bus.cdb1_val;
                            r_ent[i].rk <= 1'b1;
                        end
                    end
                end
            end
            if (w_disp_go)
                r_ent[w_free_idx] <= w_new;
        end
    end

    assign bus.rs_full     = w_full;
    assign bus.issue_valid = r_iss_valid;
    assign bus.issue_opt   = r_iss_opt;
    assign bus.issue_rs1   = r_iss_rs1;
    assign bus.issue_rs2   = r_iss_rs2;
    assign bus.issue_imm   = r_iss_imm;
    assign bus.issue_pc    = r_iss_pc;
    assign bus.issue_rob   = r_iss_rob;

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Directed bench for alu_rs_scheduler with hand-computed expectations.
module tb_alu_rs_scheduler;
    import alu_rs_scheduler_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    logic clr = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    alu_rs_scheduler_if bus();

    alu_rs_scheduler dut (
        .clk_in   (clk),
        .rst_in   (rst),
        .rdy_in   (rdy),
        .clear_in (clr),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.disp_valid = 1'b0;
        bus.cdb0_valid = 1'b0;
        bus.cdb1_valid = 1'b0;
    endtask

    task automatic disp(input opt_e op, input logic [3:0] rob, input logic [31:0] vj,
                        input logic [31:0] vk, input logic [3:0] qj, input logic [3:0] qk,
                        input logic rj, input logic rk);
        bus.disp_valid    = 1'b1;
        bus.disp_opt      = op;
        bus.disp_rob      = rob;
        bus.disp_vj       = vj;
        bus.disp_vk       = vk;
        bus.disp_qj       = qj;
        bus.disp_qk       = qk;
        bus.disp_qj_ready = rj;
        bus.disp_qk_ready = rk;
        bus.disp_imm      = 32'h100 + 32'(rob);
        bus.disp_pc       = 32'h4000 + 32'(rob);
    endtask

    task automatic cdb0(input logic [3:0] rob, input logic [31:0] val);
        bus.cdb0_valid = 1'b1;
        bus.cdb0_rob   = rob;
        bus.cdb0_val   = val;
    endtask

    task automatic cdb1(input logic [3:0] rob, input logic [31:0] val);
        bus.cdb1_valid = 1'b1;
        bus.cdb1_rob   = rob;
        bus.cdb1_val   = val;
    endtask

    initial begin
        idle();
        disp(OPT_NONE, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        bus.disp_valid = 1'b0;
        bus.cdb0_rob = '0; bus.cdb0_val = '0;
        bus.cdb1_rob = '0; bus.cdb1_val = '0;

        // reset state
        #12;
        chk("rst_valid", 64'(bus.issue_valid), 0);
        chk("rst_full",  64'(bus.rs_full), 0);
        chk("rst_rs1",   64'(bus.issue_rs1), 0);
        chk("rst_opt",   64'(bus.issue_opt), 0);
        @(negedge clk);
        rst = 1'b0;

        // ready ADD: issue exactly two edges after dispatch
        disp(OPT_ADD, 3, 5, 7, 0, 0, 1'b1, 1'b1);
        tick();
        chk("add_e1_valid", 64'(bus.issue_valid), 0);
        idle();
        tick();
        chk("add_valid", 64'(bus.issue_valid), 1);
        chk("add_rs1",   64'(bus.issue_rs1), 5);
        chk("add_rs2",   64'(bus.issue_rs2), 7);
        chk("add_rob",   64'(bus.issue_rob), 3);
        chk("add_opt",   64'(bus.issue_opt), 64'(OPT_ADD));
        chk("add_imm",   64'(bus.issue_imm), 32'h103);
        chk("add_pc",    64'(bus.issue_pc), 32'h4003);
        tick();
        chk("add_after_valid", 64'(bus.issue_valid), 0);
        chk("add_hold_rs1",    64'(bus.issue_rs1), 5);

        // SUB waiting on tag 9, woken by cdb1
        disp(OPT_SUB, 2, 0, 1, 9, 0, 1'b0, 1'b1);
        tick();
        idle();
        tick();
        chk("sub_wait_valid", 64'(bus.issue_valid), 0);
        cdb1(9, 32'h10);
        tick();
        chk("sub_wake_valid", 64'(bus.issue_valid), 0);
        idle();
        tick();
        chk("sub_valid", 64'(bus.issue_valid), 1);
        chk("sub_rs1",   64'(bus.issue_rs1), 32'h10);
        chk("sub_rob",   64'(bus.issue_rob), 2);
        tick();

        // forwarding at dispatch from cdb0
        disp(OPT_XOR, 5, 1, 0, 0, 4, 1'b1, 1'b0);
        cdb0(4, 32'hABCD);
        tick();
        idle();
        tick();
        chk("fwd_valid", 64'(bus.issue_valid), 1);
        chk("fwd_rs2",   64'(bus.issue_rs2), 32'hABCD);
        chk("fwd_rob",   64'(bus.issue_rob), 5);
        tick();

        // both CDB ports match the same tag at dispatch: cdb0 wins
        disp(OPT_OR, 6, 0, 2, 6, 0, 1'b0, 1'b1);
        cdb0(6, 32'h111);
        cdb1(6, 32'h222);
        tick();
        idle();
        tick();
        chk("prio_valid", 64'(bus.issue_valid), 1);
        chk("prio_rs1",   64'(bus.issue_rs1), 32'h111);
        tick();

        // fill all 8 slots; entry i waits on tag i+8
        for (int i = 0; i < 8; i++) begin
            disp(OPT_AND, 4'(i), 0, 32'(i), 4'(i + 8), 0, 1'b0, 1'b1);
            tick();
            if (i == 6) chk("fill7_full", 64'(bus.rs_full), 0);
        end
        chk("fill8_full", 64'(bus.rs_full), 1);
        disp(OPT_ADD, 15, 32'h99, 32'h99, 0, 0, 1'b1, 1'b1);
        tick();
        chk("drop_full",  64'(bus.rs_full), 1);
        chk("drop_valid", 64'(bus.issue_valid), 0);
        idle();
        cdb0(13, 32'h55);
        tick();
        chk("wake5_e1_valid", 64'(bus.issue_valid), 0);
        chk("wake5_e1_full",  64'(bus.rs_full), 1);
        idle();
        tick();
        chk("e5_valid", 64'(bus.issue_valid), 1);
        chk("e5_rob",   64'(bus.issue_rob), 5);
        chk("e5_rs1",   64'(bus.issue_rs1), 32'h55);
        chk("e5_full",  64'(bus.rs_full), 0);
        tick();
        chk("dropped_not_issued", 64'(bus.issue_valid), 0);

        // entries 1 and 6 woken on the same edge
        cdb0(9, 32'h91);
        cdb1(14, 32'hE6);
        tick();
        idle();
        tick();
        chk("pair_first_rob", 64'(bus.issue_rob), 1);
        chk("pair_first_rs1", 64'(bus.issue_rs1), 32'h91);
        tick();
        chk("pair_second_valid", 64'(bus.issue_valid), 1);
        chk("pair_second_rob",   64'(bus.issue_rob), 6);
        chk("pair_second_rs1",   64'(bus.issue_rs1), 32'hE6);
        tick();
        chk("pair_done_valid", 64'(bus.issue_valid), 0);

        // freeze with rdy low while an issue is being presented
        cdb0(10, 32'hA2);
        tick();
        idle();
        tick();
        chk("pre_freeze_rob", 64'(bus.issue_rob), 2);
        rdy = 1'b0;
        disp(OPT_ADD, 12, 1, 1, 0, 0, 1'b1, 1'b1);
        cdb0(8, 32'h80);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("freeze_valid", 64'(bus.issue_valid), 1);
            chk("freeze_rob",   64'(bus.issue_rob), 2);
            chk("freeze_rs1",   64'(bus.issue_rs1), 32'hA2);
        end
        rdy = 1'b1;
        idle();
        tick();
        chk("unfreeze_valid", 64'(bus.issue_valid), 0);

        // flush with 4 busy entries plus a concurrent dispatch and wake-up
        clr = 1'b1;
        disp(OPT_ADD, 1, 3, 3, 0, 0, 1'b1, 1'b1);
        cdb0(11, 32'hB3);
        tick();
        chk("clr_valid", 64'(bus.issue_valid), 0);
        chk("clr_full",  64'(bus.rs_full), 0);
        clr = 1'b0;
        idle();
        tick();
        chk("post_clr_valid", 64'(bus.issue_valid), 0);
        for (int i = 0; i < 8; i++) begin
            disp(OPT_SLT, 4'(i), 0, 0, 0, 0, 1'b0, 1'b1);
            tick();
            if (i == 6) chk("refill7_full", 64'(bus.rs_full), 0);
        end
        idle();
        chk("refill8_full", 64'(bus.rs_full), 1);

        // async reset mid-operation
        #2;
        rst = 1'b1;
        #2;
        chk("arst_full",  64'(bus.rs_full), 0);
        chk("arst_valid", 64'(bus.issue_valid), 0);
        chk("arst_rs1",   64'(bus.issue_rs1), 0);
        chk("arst_rob",   64'(bus.issue_rob), 0);
        tick();
        chk("arst_held_valid", 64'(bus.issue_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
